// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave that deframes {rw, addr, data} transactions and turns them into
// single-cycle register-bus read/write strobes, returning read data on MISO.
module spi_reg_slave #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_csl,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdat,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdat
);

    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int WAIT_W    = $clog2(RD_LAT + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] csl_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_dd_r;
    logic                   armed_r;
    logic                   rw_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [WAIT_W-1:0]      rd_wait_r;
    logic [ADDR_W:0]        hdr_sr_r;
    logic [DATA_W-1:0]      rx_sr_r;
    logic [DATA_W-1:0]      tx_sr_r;

    logic                   sclk_d_s;
    logic                   mosi_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   cs_act_s;
    logic [ADDR_W:0]        hdr_nxt_s;
    logic [DATA_W-1:0]      rx_nxt_s;

    assign sclk_d_s  = sclk_sync_r[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_r[SYNC_STAGES-1];
    assign cs_act_s  = ~csl_sync_r[SYNC_STAGES-1];
    assign rise_s    = sclk_d_s & ~sclk_dd_r;
    assign fall_s    = ~sclk_d_s & sclk_dd_r;
    // Shifter contents including the bit arriving on this rise, so the strobe can fire on that same clk.
    assign hdr_nxt_s = {hdr_sr_r[ADDR_W-1:0], mosi_s};
    assign rx_nxt_s  = {rx_sr_r[DATA_W-2:0], mosi_s};

    // Synchronise the SPI pins and keep one extra SCLK stage for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            csl_sync_r  <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_dd_r   <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
            csl_sync_r  <= {csl_sync_r[SYNC_STAGES-2:0], spi_csl};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            sclk_dd_r   <= sclk_d_s;
        end
    end

    // Frame FSM: header/data deframing, register strobes and MISO serialisation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            armed_r   <= 1'b0;
            rw_r      <= 1'b0;
            bit_cnt_r <= {CNT_W{1'b0}};
            rd_wait_r <= {WAIT_W{1'b0}};
            hdr_sr_r  <= {(ADDR_W+1){1'b0}};
            rx_sr_r   <= {DATA_W{1'b0}};
            tx_sr_r   <= {DATA_W{1'b0}};
            spi_miso  <= 1'b0;
            reg_addr  <= {ADDR_W{1'b0}};
            reg_wdat  <= {DATA_W{1'b0}};
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            // A frame may only start once CSL has been seen high since reset.
            if (!cs_act_s) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
            if (!cs_act_s) begin
                state_r   <= IDLE;
                bit_cnt_r <= {CNT_W{1'b0}};
                rd_wait_r <= {WAIT_W{1'b0}};
                spi_miso  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (armed_r) begin
                            state_r   <= HDR;
                            bit_cnt_r <= {CNT_W{1'b0}};
                            hdr_sr_r  <= {(ADDR_W+1){1'b0}};
                            rx_sr_r   <= {DATA_W{1'b0}};
                            tx_sr_r   <= {DATA_W{1'b0}};
                            spi_miso  <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    HDR: begin
                        if (rise_s) begin
                            hdr_sr_r  <= hdr_nxt_s;
                            bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            if (bit_cnt_r == CNT_W'(ADDR_W)) begin
                                reg_addr <= hdr_nxt_s[ADDR_W-1:0];
                                rw_r     <= hdr_nxt_s[ADDR_W];
                                reg_re   <= hdr_nxt_s[ADDR_W];
                                if (hdr_nxt_s[ADDR_W]) begin
                                    rd_wait_r <= WAIT_W'(RD_LAT + 1);
                                end else begin
                                    rd_wait_r <= {WAIT_W{1'b0}};
                                end
                                state_r <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        // Count out the read latency; the reg_re clk itself is not a valid sample point.
                        if (rd_wait_r != {WAIT_W{1'b0}}) begin
                            rd_wait_r <= rd_wait_r - {{(WAIT_W-1){1'b0}}, 1'b1};
                            if (rd_wait_r == {{(WAIT_W-1){1'b0}}, 1'b1}) begin
                                tx_sr_r <= reg_rdat;
                            end
                        end
                        if (fall_s && rw_r) begin
                            spi_miso <= tx_sr_r[DATA_W-1];
                            tx_sr_r  <= {tx_sr_r[DATA_W-2:0], 1'b0};
                        end
                        if (rise_s) begin
                            rx_sr_r   <= rx_nxt_s;
                            bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            if (bit_cnt_r == CNT_W'(FRAME_LEN - 1)) begin
                                if (!rw_r) begin
                                    reg_wdat <= rx_nxt_s;
                                    reg_we   <= 1'b1;
                                end
                                state_r <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: bit-banged SPI host, a one-cycle-latency register
// model, and strobe monitors checked per scenario.
module tb_spi_reg_slave;

    localparam int HALF = 8;
    localparam int GAP  = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_csl = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [6:0]  reg_addr;
    logic [31:0] reg_wdat;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdat = 32'h0;

    int checks = 0;
    int passes = 0;

    int          we_cnt = 0, re_cnt = 0, both_cnt = 0, we_long = 0, re_long = 0;
    logic        we_q = 1'b0, re_q = 1'b0;
    logic [6:0]  we_addr = 7'h0, re_addr_prev = 7'h0, re_addr_last = 7'h0;
    logic [31:0] we_data = 32'h0;

    spi_reg_slave dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .spi_csl  (spi_csl),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .reg_addr (reg_addr),
        .reg_wdat (reg_wdat),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdat (reg_rdat)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_rd(input logic [6:0] a);
        case (a)
            7'h00:   model_rd = 32'h12345678;
            7'h0E:   model_rd = 32'hCAFEF00D;
            7'h0F:   model_rd = 32'h0F0F1234;
            default: model_rd = {25'h0, a};
        endcase
    endfunction

    // Register file model with one clk of read latency.
    always @(posedge clk) begin
        if (reg_re) reg_rdat <= model_rd(reg_addr);
    end

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reg_we && reg_re) both_cnt++;
        if (reg_we) begin
            we_cnt++;
            we_addr = reg_addr;
            we_data = reg_wdat;
            if (we_q) we_long++;
        end
        if (reg_re) begin
            re_cnt++;
            re_addr_prev = re_addr_last;
            re_addr_last = reg_addr;
            if (re_q) re_long++;
        end
        we_q = reg_we;
        re_q = reg_re;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives nbits SCLK periods; returns read data sampled on rises 9..40 and the
    // number of MISO ones seen where MISO must be 0.
    task automatic xfer(input logic rw, input logic [6:0] addr, input logic [31:0] data,
                        input int nbits, input bit keep_cs,
                        output logic [31:0] rdata, output int bad_ones);
        logic [39:0] frame;
        logic        s;
        frame    = {rw, addr, data};
        rdata    = 32'h0;
        bad_ones = 0;
        spi_csl  = 1'b0;
        wait_clks(4);
        for (int i = 0; i < nbits; i++) begin
            spi_sclk = 1'b0;
            spi_mosi = (i < 40) ? frame[39-i] : 1'b0;
            wait_clks(HALF);
            s = spi_miso;
            if (rw && i >= 8 && i < 40) rdata = {rdata[30:0], s};
            else if (s) bad_ones++;
            spi_sclk = 1'b1;
            wait_clks(HALF);
        end
        if (!keep_cs) begin
            spi_sclk = 1'b0;
            wait_clks(HALF);
            spi_csl = 1'b1;
            wait_clks(GAP);
        end
    endtask

    task automatic test_reset;
        wait_clks(3);
        checks++; if (reg_we !== 1'b0 || reg_re !== 1'b0) $display("FAIL reset_strobes we=%b re=%b required 0/0", reg_we, reg_re); else passes++;
        checks++; if (reg_addr !== 7'h0 || reg_wdat !== 32'h0 || spi_miso !== 1'b0)
            $display("FAIL reset_outputs addr=%h wdat=%h miso=%b required 0", reg_addr, reg_wdat, spi_miso); else passes++;
        reset_n = 1'b1;
        wait_clks(GAP);
    endtask

    task automatic test_read;
        logic [31:0] rd; int bad; int re0, we0;
        re0 = re_cnt; we0 = we_cnt;
        xfer(1'b1, 7'h00, 32'h0, 40, 1'b0, rd, bad);
        checks++; if (rd !== 32'h12345678) $display("FAIL read_data got=%h required=12345678", rd); else passes++;
        checks++; if (re_cnt - re0 !== 1 || re_addr_last !== 7'h00) $display("FAIL read_strobe count=%0d addr=%h required 1/00", re_cnt - re0, re_addr_last); else passes++;
        checks++; if (we_cnt - we0 !== 0) $display("FAIL read_no_we count=%0d required 0", we_cnt - we0); else passes++;
        checks++; if (bad !== 0) $display("FAIL read_miso_idle ones=%0d required 0", bad); else passes++;
    endtask

    task automatic test_write;
        logic [31:0] rd; int bad; int we0;
        we0 = we_cnt;
        xfer(1'b0, 7'h0A, 32'h00000030, 40, 1'b0, rd, bad);
        checks++; if (we_cnt - we0 !== 1) $display("FAIL write_count got=%0d required 1", we_cnt - we0); else passes++;
        checks++; if (we_addr !== 7'h0A || we_data !== 32'h30) $display("FAIL write_addr_data got=%h/%h required 0a/00000030", we_addr, we_data); else passes++;
        checks++; if (bad !== 0) $display("FAIL write_miso ones=%0d required 0", bad); else passes++;
    endtask

    task automatic test_abort;
        logic [31:0] rd; int bad; int we0;
        we0 = we_cnt;
        xfer(1'b0, 7'h0C, 32'hFFFFFFFF, 20, 1'b0, rd, bad);
        checks++; if (we_cnt - we0 !== 0) $display("FAIL abort_no_we got=%0d required 0", we_cnt - we0); else passes++;
        xfer(1'b0, 7'h0C, 32'h00000001, 40, 1'b0, rd, bad);
        checks++; if (we_cnt - we0 !== 1 || we_addr !== 7'h0C || we_data !== 32'h1)
            $display("FAIL abort_recover count=%0d addr=%h data=%h required 1/0c/00000001", we_cnt - we0, we_addr, we_data); else passes++;
    endtask

    task automatic test_overlong;
        logic [31:0] rd; int bad; int we0;
        we0 = we_cnt;
        xfer(1'b0, 7'h03, 32'h00000001, 48, 1'b0, rd, bad);
        checks++; if (we_cnt - we0 !== 1 || we_data !== 32'h1 || we_addr !== 7'h03)
            $display("FAIL overlong_we count=%0d addr=%h data=%h required 1/03/00000001", we_cnt - we0, we_addr, we_data); else passes++;
        checks++; if (bad !== 0) $display("FAIL overlong_miso ones=%0d required 0", bad); else passes++;
    endtask

    task automatic test_midframe_reset;
        logic [31:0] rd; int bad; int we0;
        we0 = we_cnt;
        xfer(1'b0, 7'h05, 32'hA5A5A5A5, 30, 1'b1, rd, bad);
        reset_n = 1'b0;
        #1;
        checks++; if (reg_we !== 1'b0 || reg_re !== 1'b0 || reg_addr !== 7'h0 || reg_wdat !== 32'h0 || spi_miso !== 1'b0)
            $display("FAIL midreset_outputs we=%b re=%b addr=%h wdat=%h miso=%b required all 0", reg_we, reg_re, reg_addr, reg_wdat, spi_miso); else passes++;
        spi_sclk = 1'b0;
        wait_clks(5);
        reset_n = 1'b1;
        wait_clks(5);
        spi_csl = 1'b1;
        wait_clks(GAP);
        checks++; if (we_cnt - we0 !== 0) $display("FAIL midreset_no_we got=%0d required 0", we_cnt - we0); else passes++;
        xfer(1'b1, 7'h0E, 32'h0, 40, 1'b0, rd, bad);
        checks++; if (rd !== 32'hCAFEF00D) $display("FAIL midreset_read got=%h required cafef00d", rd); else passes++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd0, rd1; int bad0, bad1; int re0;
        re0 = re_cnt;
        xfer(1'b1, 7'h0E, 32'h0, 40, 1'b0, rd0, bad0);
        xfer(1'b1, 7'h0F, 32'h0, 40, 1'b0, rd1, bad1);
        checks++; if (re_cnt - re0 !== 2 || re_addr_prev !== 7'h0E || re_addr_last !== 7'h0F)
            $display("FAIL b2b_strobes count=%0d addrs=%h,%h required 2/0e,0f", re_cnt - re0, re_addr_prev, re_addr_last); else passes++;
        checks++; if (rd0 !== 32'hCAFEF00D || rd1 !== 32'h0F0F1234)
            $display("FAIL b2b_data got=%h,%h required cafef00d,0f0f1234", rd0, rd1); else passes++;
    endtask

    task automatic test_strobe_shape;
        checks++; if (both_cnt !== 0) $display("FAIL strobe_overlap got=%0d required 0", both_cnt); else passes++;
        checks++; if (we_long !== 0 || re_long !== 0) $display("FAIL strobe_width we_long=%0d re_long=%0d required 0/0", we_long, re_long); else passes++;
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_abort;
        test_overlong;
        test_midframe_reset;
        test_back_to_back;
        test_strobe_shape;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
